// File: rtl/gyro_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the gyro bias calibrator.
package gyro_pkg;
    localparam int AXIS_W   = 16;
    localparam int NUM_AXES = 3;

    typedef enum logic {CALIB = 1'b0, RUN = 1'b1} state_t;

    localparam logic signed [AXIS_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [AXIS_W-1:0] SAT_MIN = 16'sh8000;
endpackage

// File: rtl/gyro_axis_cal.sv
// One axis: calibration accumulator, bias register and the
// subtract / saturate / deadband output path.
module gyro_axis_cal import gyro_pkg::*; #(
    parameter int                CAL_LOG2 = 4,
    parameter logic [AXIS_W-1:0] DEADBAND = 16'd8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    input  logic                     bias_ld,
    input  logic                     out_en,
    input  logic signed [AXIS_W-1:0] din,
    output logic signed [AXIS_W-1:0] dout
);
    localparam int ACC_W = AXIS_W + CAL_LOG2;

    logic signed [ACC_W-1:0]  acc, sum;
    logic signed [AXIS_W-1:0] bias, sat, res;
    logic signed [AXIS_W:0]   diff;
    logic        [AXIS_W:0]   mag;

    always_comb begin
        sum  = acc + {{CAL_LOG2{din[AXIS_W-1]}}, din};
        diff = {din[AXIS_W-1], din} - {bias[AXIS_W-1], bias};
        // Top two bits disagree only when the 17-bit difference left 16-bit range.
        if (diff[AXIS_W] != diff[AXIS_W-1])
            sat = diff[AXIS_W] ? SAT_MIN : SAT_MAX;
        else
            sat = diff[AXIS_W-1:0];
        mag = sat[AXIS_W-1] ? -{sat[AXIS_W-1], sat} : {sat[AXIS_W-1], sat};
        res = (mag <= {1'b0, DEADBAND}) ? '0 : sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            bias <= '0;
            dout <= '0;
        end else begin
            if (acc_clr)     acc <= '0;
            else if (acc_en) acc <= sum;
            // Arithmetic shift by CAL_LOG2 (floor) is just a bit-slice of the sum.
            if (bias_ld) bias <= sum[CAL_LOG2 +: AXIS_W];
            if (out_en)  dout <= res;
        end
    end
endmodule

// File: rtl/gyro_bias_cal.sv
// Zero-rate bias calibration and correction for PmodGYRO X/Y/Z samples.
// Top holds the CALIB/RUN FSM, the sample counter and the output strobes.
module gyro_bias_cal import gyro_pkg::*; #(
    parameter int                CAL_LOG2 = 4,
    parameter logic [AXIS_W-1:0] DEADBAND = 16'd8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [AXIS_W-1:0] x_in,
    input  logic [AXIS_W-1:0] y_in,
    input  logic [AXIS_W-1:0] z_in,
    input  logic              recal,
    output logic [AXIS_W-1:0] x_out,
    output logic [AXIS_W-1:0] y_out,
    output logic [AXIS_W-1:0] z_out,
    output logic              out_valid,
    output logic              calib_done
);
    state_t                             state, state_nxt;
    logic [CAL_LOG2-1:0]                cnt;
    logic                               acc_en, acc_clr, bias_ld, out_en, cnt_clr;
    logic [NUM_AXES-1:0][AXIS_W-1:0]    din_v, dout_v;

    assign din_v = {z_in, y_in, x_in};
    assign x_out = dout_v[0];
    assign y_out = dout_v[1];
    assign z_out = dout_v[2];
    assign calib_done = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CALIB;
        else      state <= state_nxt;
    end

    // recal wins over everything, including a coincident sample.
    always_comb begin
        state_nxt = state;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        bias_ld   = 1'b0;
        out_en    = 1'b0;
        cnt_clr   = 1'b0;
        if (recal) begin
            state_nxt = CALIB;
            acc_clr   = 1'b1;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                CALIB: if (sample_valid) begin
                    acc_en = 1'b1;
                    if (cnt == '1) begin
                        bias_ld   = 1'b1;
                        acc_clr   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: out_en = sample_valid;
                default: state_nxt = CALIB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_en;
            if (cnt_clr)     cnt <= '0;
            else if (acc_en) cnt <= cnt + CAL_LOG2'(1);
        end
    end

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        gyro_axis_cal #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND)) u_axis (
            .clk     (clk),
            .rst     (rst),
            .acc_en  (acc_en),
            .acc_clr (acc_clr),
            .bias_ld (bias_ld),
            .out_en  (out_en),
            .din     (din_v[i]),
            .dout    (dout_v[i])
        );
    end
endmodule

// File: tb/tb_gyro_bias_cal.sv
// Scoreboard bench for gyro_bias_cal: expected corrected frames are queued as
// stimulus is driven and popped when out_valid fires.
module tb_gyro_bias_cal;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic        recal = 1'b0;
    logic [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic [15:0] x_out, y_out, z_out;
    logic        out_valid, calib_done;

    gyro_bias_cal #(.CAL_LOG2(4), .DEADBAND(16'd8)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .recal(recal),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .out_valid(out_valid), .calib_done(calib_done)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int z; } exp_t;
    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, rx_cnt = 0, rx_first = -1, rx_last = -1;

    // Reference model state, kept independently of the DUT.
    bit   m_run = 0;
    int   m_cnt = 0;
    int   m_sum[3] = '{0, 0, 0};
    int   m_bias[3] = '{0, 0, 0};

    function automatic int corr(input int v, input int b);
        int d;
        d = v - b;
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        if (d <= 8 && d >= -8) d = 0;
        return d;
    endfunction

    function automatic void model_clear();
        m_run = 0; m_cnt = 0;
        for (int a = 0; a < 3; a++) m_sum[a] = 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            exp_t e;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out_valid: got x=%0d y=%0d z=%0d, required no pulse",
                         $signed(x_out), $signed(y_out), $signed(z_out));
            end else begin
                e = q.pop_front();
                if ($signed(x_out) !== e.x || $signed(y_out) !== e.y || $signed(z_out) !== e.z) begin
                    n_bad++;
                    $display("FAIL scoreboard_frame: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                             $signed(x_out), $signed(y_out), $signed(z_out), e.x, e.y, e.z);
                end
            end
            rx_cnt++;
            if (rx_first < 0) rx_first = cyc;
            rx_last = cyc;
        end
    end

    task automatic drive_frame(input int x, input int y, input int z);
        int v[3];
        v = '{x, y, z};
        @(negedge clk);
        sample_valid = 1'b1;
        x_in = 16'(x); y_in = 16'(y); z_in = 16'(z);
        if (m_run) begin
            q.push_back('{corr(x, m_bias[0]), corr(y, m_bias[1]), corr(z, m_bias[2])});
        end else begin
            for (int a = 0; a < 3; a++) m_sum[a] += v[a];
            m_cnt++;
            if (m_cnt == 16) begin
                for (int a = 0; a < 3; a++) m_bias[a] = m_sum[a] >>> 4;
                model_clear();
                m_run = 1;
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_recal(input bit with_sample, input int x);
        @(negedge clk);
        recal = 1'b1;
        sample_valid = with_sample;
        x_in = 16'(x);
        model_clear();
        @(negedge clk);
        recal = 1'b0;
        sample_valid = 1'b0;
        n_cmp++;
        if (calib_done !== 1'b0) begin
            n_bad++; $display("FAIL recal_calib_done: got %b, required 0", calib_done);
        end
    endtask

    task automatic check_done(input string name, input logic want);
        n_cmp++;
        if (calib_done !== want) begin
            n_bad++; $display("FAIL %s: calib_done got %b, required %b", name, calib_done, want);
        end
    endtask

    task automatic check_x(input string name, input int want);
        n_cmp++;
        if ($signed(x_out) !== want) begin
            n_bad++; $display("FAIL %s: x_out got %0d, required %0d", name, $signed(x_out), want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (x_out !== 16'd0 || y_out !== 16'd0 || z_out !== 16'd0 || out_valid !== 1'b0 || calib_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got x=%0h y=%0h z=%0h ov=%b cd=%b, required all 0",
                     x_out, y_out, z_out, out_valid, calib_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_cal();
        for (int i = 0; i < 15; i++) drive_frame(100, -50, 0);
        check_done("basic_done_before_16", 1'b0);
        drive_frame(100, -50, 0);
        check_done("basic_done_after_16", 1'b1);
        drive_frame(150, -50, 5);
        @(negedge clk);
        check_x("basic_x_out", 50);
        n_cmp++;
        if (y_out !== 16'd0 || z_out !== 16'd0) begin
            n_bad++; $display("FAIL basic_yz_out: got y=%0d z=%0d, required 0 0", $signed(y_out), $signed(z_out));
        end
    endtask

    task automatic test_saturation();
        pulse_recal(0, 0);
        for (int i = 0; i < 16; i++) drive_frame(-32000, 0, 0);
        check_done("sat_pos_done", 1'b1);
        drive_frame(32767, 0, 0);
        check_x("sat_pos_x", 32767);
        pulse_recal(0, 0);
        for (int i = 0; i < 16; i++) drive_frame(32000, 0, 0);
        drive_frame(-32768, 0, 0);
        check_x("sat_neg_x", -32768);
    endtask

    task automatic test_rounding();
        pulse_recal(0, 0);
        for (int i = 0; i < 16; i++) drive_frame((i % 2) ? 4 : 3, 0, 0);
        drive_frame(12, 0, 0);
        check_x("round_x12", 9);
        drive_frame(11, 0, 0);
        check_x("deadband_edge_x11", 0);
        drive_frame(-6, 0, 0);
        check_x("deadband_neg_edge", -9);
    endtask

    task automatic test_recal_with_sample();
        drive_frame(20, 0, 0);
        check_x("pre_recal_x", 17);
        pulse_recal(1, 999);
        check_x("recal_hold_x", 17);
        for (int i = 0; i < 16; i++) drive_frame(10, 0, 0);
        check_x("recal_hold_after_cal", 17);
        check_done("recal_done_again", 1'b1);
        drive_frame(30, 0, 0);
        check_x("recal_new_bias", 20);
    endtask

    task automatic test_reset_mid_cal();
        pulse_recal(0, 0);
        for (int i = 0; i < 7; i++) drive_frame(1000, 0, 0);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (x_out !== 16'd0 || y_out !== 16'd0 || z_out !== 16'd0 || out_valid !== 1'b0 || calib_done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got x=%0d ov=%b cd=%b, required 0 0 0",
                     $signed(x_out), out_valid, calib_done);
        end
        model_clear();
        for (int a = 0; a < 3; a++) m_bias[a] = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) drive_frame(40, 0, 0);
        check_done("mid_reset_15_frames", 1'b0);
        drive_frame(40, 0, 0);
        check_done("mid_reset_16_frames", 1'b1);
        drive_frame(100, 0, 0);
        check_x("mid_reset_new_bias", 60);
    endtask

    task automatic test_back_to_back();
        int base;
        base = rx_cnt;
        rx_first = -1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            x_in = 16'(100 + i); y_in = 16'(-100 - i); z_in = 16'(0);
            q.push_back('{corr(100 + i, m_bias[0]), corr(-100 - i, m_bias[1]), corr(0, m_bias[2])});
            @(negedge clk);
        end
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rx_cnt - base !== 5 || rx_last - rx_first !== 4) begin
            n_bad++;
            $display("FAIL back_to_back_pulses: got %0d pulses over span %0d, required 5 over 4",
                     rx_cnt - base, rx_last - rx_first);
        end
    endtask

    initial begin
        test_reset();
        test_basic_cal();
        test_saturation();
        test_rounding();
        test_recal_with_sample();
        test_reset_mid_cal();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
